// File: rtl/reward_packer_if.sv
// reward_packer_if: word-wide valid/ready transmit channel from the packer to
// the radio/TX queue. The master drives data/valid/last; the slave drives ready.
interface reward_packer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/reward_packer.sv
// reward_packer: on an en pulse, snapshots node / cluster-head / neighbour
// fields and streams an EER-RL packet (HB, INV, MR, DATA, SOS, CHTS) one word
// per handshake. Illegal types and over-limit invitations are dropped.
//
// Optional feature: define REWARD_CHECKSUM_EN to append a ninth word holding
// the XOR of words 0..7 (tx_last then moves onto that word).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for en; rejects illegal requests with a drop pulse
// S_SEND | tx_valid high, presenting the word at the current index
// S_DONE | one cycle with reward_done high, then back to S_IDLE
//
// tx_data/tx_valid/tx_last are registers, so tx_ready only ever reaches them
// through a flop; the next word is prepared combinationally from the latched
// fields and loaded on acceptance.
module reward_packer #(
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    MAX_CH_HOPS = 4,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID    = {WORD_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            pkt_type,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    reward_packer_if.master       tx,
    output logic                  busy,
    output logic                  reward_done,
    output logic                  drop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] T_HB   = 3'd1;
    localparam logic [2:0] T_INV  = 3'd2;
    localparam logic [2:0] T_MR   = 3'd3;
    localparam logic [2:0] T_DATA = 3'd4;
    localparam logic [2:0] T_SOS  = 3'd5;
    localparam logic [2:0] T_CHTS = 3'd6;

`ifdef REWARD_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    localparam logic [WORD_WIDTH-1:0] MAX_HOPS_W = WORD_WIDTH'(MAX_CH_HOPS);
    localparam logic [WORD_WIDTH-1:0] ALL_ONES   = {WORD_WIDTH{1'b1}};

    logic [1:0]            state_q;
    logic [3:0]            idx_q;
    logic [3:0]            word_sel;

    logic [2:0]            type_q;
    logic [WORD_WIDTH-1:0] node_q;
    logic [WORD_WIDTH-1:0] energy_q;
    logic [WORD_WIDTH-1:0] qvalue_q;
    logic [WORD_WIDTH-1:0] sink_hops_q;
    logic [WORD_WIDTH-1:0] ch_q;
    logic [WORD_WIDTH-1:0] ch_hops_q;
    logic [WORD_WIDTH-1:0] mnode_q;

    logic                  type_legal;
    logic                  inv_over_limit;
    logic                  reject;
    logic [WORD_WIDTH-1:0] dest_id;
    logic [WORD_WIDTH-1:0] hops_field;
    logic [WORD_WIDTH-1:0] type_field;
    logic [WORD_WIDTH-1:0] next_word;
`ifdef REWARD_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum;
`endif

    assign busy = (state_q != S_IDLE);

    // Request screening: only types 1..6 are legal; an invitation that has
    // already reached the hop limit is not forwarded.
    assign type_legal     = (pkt_type != 3'd0) && (pkt_type != 3'd7);
    assign inv_over_limit = (pkt_type == T_INV) && (hopsFromCH >= MAX_HOPS_W);
    assign reject         = !type_legal || inv_over_limit;

    assign type_field = WORD_WIDTH'(type_q);
    assign word_sel   = idx_q + 4'd1;

    // Packet-type dependent fields built from the latched snapshot.
    always_comb begin
        dest_id    = BCAST_ID;
        hops_field = ch_hops_q;
        case (type_q)
            T_HB, T_INV, T_CHTS: dest_id = BCAST_ID;
            T_MR:                dest_id = ch_q;
            T_DATA, T_SOS:       dest_id = mnode_q;
            default:             dest_id = BCAST_ID;
        endcase
        if (type_q == T_INV) begin
            hops_field = (ch_hops_q == ALL_ONES) ? ALL_ONES : ch_hops_q + 1'b1;
        end
    end

`ifdef REWARD_CHECKSUM_EN
    // Checksum over the eight data words of the latched packet.
    always_comb begin
        checksum = node_q ^ energy_q ^ qvalue_q ^ sink_hops_q ^
                   dest_id ^ type_field ^ ch_q ^ hops_field;
    end
`endif

    // Word that follows the current index; loaded into tx_data on acceptance.
    always_comb begin
        next_word = '0;
        case (word_sel)
            4'd0: next_word = node_q;
            4'd1: next_word = energy_q;
            4'd2: next_word = qvalue_q;
            4'd3: next_word = sink_hops_q;
            4'd4: next_word = dest_id;
            4'd5: next_word = type_field;
            4'd6: next_word = ch_q;
            4'd7: next_word = hops_field;
`ifdef REWARD_CHECKSUM_EN
            4'd8: next_word = checksum;
`endif
            default: next_word = '0;
        endcase
    end

    // Field snapshot, taken only when a request is accepted in S_IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            type_q      <= '0;
            node_q      <= '0;
            energy_q    <= '0;
            qvalue_q    <= '0;
            sink_hops_q <= '0;
            ch_q        <= '0;
            ch_hops_q   <= '0;
            mnode_q     <= '0;
        end else if (state_q == S_IDLE && en && !reject) begin
            type_q      <= pkt_type;
            node_q      <= myNodeID;
            energy_q    <= myEnergy;
            qvalue_q    <= myQValue;
            sink_hops_q <= hopsFromSink;
            ch_q        <= chosenCH;
            ch_hops_q   <= hopsFromCH;
            mnode_q     <= mNodeID;
        end
    end

    // Sequencer: state, word index, registered TX outputs and status pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            reward_done <= 1'b0;
            drop        <= 1'b0;
        end else begin
            reward_done <= 1'b0;
            drop        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        if (reject) begin
                            drop <= 1'b1;
                        end else begin
                            idx_q       <= '0;
                            tx.tx_data  <= myNodeID;
                            tx.tx_valid <= 1'b1;
                            tx.tx_last  <= 1'b0;
                            state_q     <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (tx.tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            tx.tx_data  <= '0;
                            tx.tx_valid <= 1'b0;
                            tx.tx_last  <= 1'b0;
                            reward_done <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q      <= word_sel;
                            tx.tx_data <= next_word;
                            tx.tx_last <= (word_sel == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reward_packer.md
# reward_packer

Parameterised successor to the per-node reward stage. On an `en` pulse it snapshots node, cluster-head and neighbour-table fields, builds an outgoing EER-RL packet of the requested type (HB, INV, MR, DATA, SOS, CHTS), and streams it word-by-word over a valid/ready transmit interface to the radio/TX queue. It also enforces the invitation hop limit and drops illegal requests.

## Interface
- `WORD_WIDTH`, 16, width of every field and of `tx_data`
- `MAX_CH_HOPS`, 4, INV packets are forwarded only while `hopsFromCH < MAX_CH_HOPS`
- `BCAST_ID`, all ones (`{WORD_WIDTH{1'b1}}`), destination ID for broadcast types
- `clk`  in  1  single clock; all logic on rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `en`  in  1  start pulse; sampled only in S_IDLE
- `pkt_type`  in  3  1=HB, 2=INV, 3=MR, 4=DATA, 5=SOS, 6=CHTS; 0 and 7 are illegal
- `myNodeID`, `hopsFromSink`, `myQValue`, `myEnergy`  in  WORD_WIDTH each  own node info
- `chosenCH`, `hopsFromCH`  in  WORD_WIDTH each  own cluster-head info
- `mNodeID`  in  WORD_WIDTH  next-hop neighbour selected by the neighbour table
- `tx_data`  out  WORD_WIDTH  current packet word
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  downstream accepts the word when `tx_valid && tx_ready`
- `tx_last`  out  1  high with the final word of a packet
- `busy`  out  1  high in any state other than S_IDLE
- `reward_done`  out  1  one-cycle pulse after the last word is accepted
- `drop`  out  1  one-cycle pulse when a request is rejected

## Operation
- States: S_IDLE, S_SEND, S_DONE. On reset the FSM is in S_IDLE and every output is 0, including `tx_data`.
- S_IDLE with `en=1`:
  - Illegal type, or INV with `hopsFromCH >= MAX_CH_HOPS`: pulse `drop` on the next cycle and stay in S_IDLE.
  - Otherwise: latch all field inputs into internal registers, clear the word index, and go to S_SEND.
- Word order, index 0..7:
  - 0: sourceID = `myNodeID`
  - 1: energyLeft = `myEnergy`
  - 2: QValue = `myQValue`
  - 3: sourceHops = `hopsFromSink`
  - 4: destinationID
  - 5: packetType, zero-extended
  - 6: chosenCH = `chosenCH`
  - 7: hopsFromCH
- destinationID by type: HB, INV and CHTS use `BCAST_ID`; MR uses latched `chosenCH`; DATA and SOS use latched `mNodeID`.
- hopsFromCH field: INV carries latched `hopsFromCH + 1`, saturating at all ones. Every other type carries latched `hopsFromCH` unchanged.
- S_SEND:
  - `tx_valid=1`; `tx_data` is the word at the current index.
  - On `tx_ready`, the index advances.
  - On acceptance of the final word, go to S_DONE.
- S_DONE: `reward_done=1` for exactly one cycle, then return to S_IDLE.
- `en` is ignored while `busy=1`. No queueing: a request arriving while busy is lost without a `drop` pulse.

## Timing
- Request `en` at cycle 0 → `tx_valid` high at cycle 1, carrying word 0.
- With `tx_ready` held high: one word per cycle. `tx_last` is at cycle 8 (cycle 9 with checksum); `reward_done` follows in the next cycle.
- Minimum spacing between accepted requests: 10 cycles (11 with checksum).
- `drop` is registered and appears at cycle 1 for an `en` at cycle 0.
- While `tx_valid && !tx_ready`: `tx_data`, `tx_valid` and `tx_last` are held stable, and no combinational path from `tx_ready` to `tx_valid` or `tx_data` is allowed.
- Input fields are don't-care after the latch cycle.
- `nrst` asserted mid-packet aborts immediately: all outputs go to 0 and no `reward_done` is produced.

## Configuration
- `REWARD_CHECKSUM_EN` defined: a ninth word (index 8) is appended. It is the bitwise XOR of words 0..7. `tx_last` moves to this word, and the packet length is 9.
- Not defined: the packet is 8 words, `tx_last` is on word 7, and no checksum logic is synthesised.

## Test plan
- Reset: hold `nrst=0` with random inputs → all outputs are 0; after release, `busy=0`.
- HB: `myNodeID=0x0005`, `myEnergy=0x1234`, `tx_ready=1` → words 0005, 1234, Q, hops, FFFF, 0001, CH, hCH on cycles 1–8; `tx_last` on cycle 8; `reward_done` on cycle 9.
- INV:
  - `hopsFromCH=3` → destination FFFF, word 7 = 0004.
  - `hopsFromCH=4` → `drop` pulse, no `tx_valid`.
  - `pkt_type=0` → `drop` pulse.
- DATA with backpressure: `mNodeID=0x0009`, `tx_ready` toggled 1/0 → word 4 = 0009; every word is held while not ready; exactly 8 handshakes occur. MR sends `chosenCH` in word 4.
- Mid-packet: `en` pulsed during S_SEND → ignored. `nrst` asserted after word 3 → immediate zero outputs and no `reward_done`; the next request starts again at word 0.
- With `REWARD_CHECKSUM_EN` defined: word 8 equals the XOR of words 0–7, and `tx_last` is on word 8.
